// File: rtl/aes128_enc_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes128_enc_iter
// Purpose  : Iterative AES-128 encryptor, UNROLL chained rounds per clock.
// Revision : 1.0
// ============================================================================
module aes128_enc_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int         ITER       = 10 / UNROLL;
    localparam logic [3:0] c_step     = 4'(UNROLL);
    localparam logic [3:0] c_last_rnd = 4'(1 + (ITER - 1) * UNROLL);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
            $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (254 = 8'b1111_1110), zero maps to zero, then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, sq);
            sq = gf_mul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < 16; i++) begin
            if (4'(i) < r) rc = xtime(rc);
        end
        return rc;
    endfunction

    function automatic logic [127:0] keygeneration(input logic [3:0] r, input logic [127:0] k);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(r), 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] substitutebyte(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shiftrow(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixcol(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_fsm, w_fsm_nxt;
    logic         r_ready_en;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic [127:0] w_s_final;
    logic [127:0] w_k_final;
    logic         w_accept;
    logic         w_last;

    generate
        for (genvar g = 0; g < UNROLL; g++) begin : g_round
            logic [3:0]   w_r;
            logic [127:0] w_s_in, w_k_in, w_sr, w_s_out, w_k_out;
            if (g == 0) begin : g_first
                assign w_s_in = r_state;
                assign w_k_in = r_key;
            end else begin : g_chain
                assign w_s_in = g_round[g-1].w_s_out;
                assign w_k_in = g_round[g-1].w_k_out;
            end
            assign w_r     = r_rnd + 4'(g);
            assign w_k_out = keygeneration(w_r, w_k_in);
            assign w_sr    = shiftrow(substitutebyte(w_s_in));
            assign w_s_out = ((w_r == 4'd10) ? w_sr : mixcol(w_sr)) ^ w_k_out;
        end
    endgenerate

    assign w_s_final = g_round[UNROLL-1].w_s_out;
    assign w_k_final = g_round[UNROLL-1].w_k_out;
    assign w_accept  = (r_fsm == IDLE) && r_ready_en && in_valid;
    assign w_last    = (r_rnd == c_last_rnd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = r_ready_en;
                if (w_accept) w_fsm_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (w_last) w_fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_key    <= '0;
            r_rnd    <= '0;
            out_data <= '0;
        end else if (w_accept) begin
            r_state <= in_data ^ in_key;
            r_key   <= in_key;
            r_rnd   <= 4'd1;
        end else if (r_fsm == BUSY) begin
            r_state <= w_s_final;
            r_key   <= w_k_final;
            if (w_last) begin
                r_rnd    <= 4'd0;
                out_data <= w_s_final;
            end else begin
                r_rnd <= r_rnd + c_step;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption engine built on the team's single-round datapath: keygeneration, substitutebyte, shiftrow, mixcol.
- Accepts one plaintext/key pair through a valid/ready handshake and applies the initial AddRoundKey plus 10 rounds.
- Round 10 omits MixColumns.
- A compile-time unroll factor sets how many rounds run per clock. Iteration count, latency and area follow from it.
- Sits between the host-side block buffer and the output formatter.

Parameters:
- UNROLL, 1, rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- ITER, 10/UNROLL (derived, localparam), busy cycles per block.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key presented
- in_ready  out  1  engine can accept a block
- in_data  in  128  plaintext, byte 0 in [127:120]
- in_key  in  128  cipher key, byte 0 in [127:120]
- out_valid  out  1  ciphertext available
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext, byte 0 in [127:120]
- busy  out  1  high while in BUSY state

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (rst_n=0, asynchronous):
  - state=IDLE
  - in_ready=0 while rst_n is low, 1 from the first clk edge after deassertion
  - out_valid=0, out_data=0, busy=0
  - internal state register, round-key register and round counter all zero
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: state_reg<=in_data^in_key, key_reg<=in_key, rnd<=1, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge applies UNROLL chained rounds, r=rnd..rnd+UNROLL-1.
  - For each r: round key k_r = keygeneration(r[3:0], k_{r-1}).
  - For r<10: s = mixcol(shiftrow(substitutebyte(s))) ^ k_r.
  - For r=10: s = shiftrow(substitutebyte(s)) ^ k_r, with no mixcol.
  - rnd advances by UNROLL each cycle.
  - The edge that completes round 10 loads out_data with the ciphertext, sets out_valid=1 and moves to DONE.
- Latency: exactly ITER edges from the accepting edge to out_valid high. That is 10 for UNROLL=1, 5 for 2, 2 for 5, 1 for 10.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable until the handshake.
  - On out_ready at an edge: out_valid<=0, go to IDLE. in_ready is 1 in the following cycle.
  - No same-cycle accept in DONE. Throughput is one block per ITER+2 cycles with out_ready tied high.
- Backpressure: out_ready low holds DONE indefinitely. out_data and out_valid must not change during the hold.
- Input stability: inputs are sampled only at the accepting edge. in_data and in_key may change afterwards without effect.
- in_valid while not in IDLE is ignored; no block is queued.
- rnd width is 4 bits and never exceeds 10. No wrap is reachable.
- Reset mid-BUSY or mid-DONE:
  - Immediate return to the reset values.
  - The partial block is discarded and no out_valid pulse is produced.
- The round function is purely combinational between the state register and key register. Only state_reg, key_reg, rnd, the FSM state and out_data are registered.

Test Plan:
- Vector 1, UNROLL=1: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid rises exactly 10 edges after accept, out_data=3925841d02dc09fbdc118597196a0b32, busy high for 10 cycles.
- Vector 2, UNROLL=5: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f -> out_valid after 2 edges, out_data=69c4e0d86a7b0430d8cdb78070b4c55a. Repeat with UNROLL=2 (5 edges) and UNROLL=10 (1 edge) for the same ciphertext.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data and out_valid constant, in_ready=0 throughout. out_ready=1 -> out_valid drops next edge, in_ready=1 the cycle after.
- Ignored input: pulse in_valid with a different block during BUSY and DONE -> no effect, and the ciphertext matches the original block. Change in_data and in_key the cycle after accept -> result unchanged.
- Reset mid-op: assert rst_n=0 asynchronously 3 cycles into BUSY -> out_valid, busy and out_data go to 0 immediately. After release, run vector 1 -> correct ciphertext and latency.
- Back-to-back: two blocks with out_ready=1, in_valid held high -> second accepted ITER+2 cycles after the first, and both ciphertexts are correct.
